lcd_bus_arbiter: RTL and testbench

- Arbitrates the MCU-LCD 8080-style bus between three requesters and sequences each bus cycle: CS, RS, WR/RD strobes and data direction.
- Requester 0 is the init sequencer, requester 1 is CPU register access (Nios PIO bridge) and requester 2 is the pixel streamer.
- Sits between those sources and the LCD signal select mux, and replaces the ad-hoc strobe generation on the MCU path.
- Strobe widths are parameterised, so one build serves every supported LCD ID at the LCD clock.

---
 rtl/lcd_bus_pkg.sv | 20 ++
 rtl/lcd_bus_prio_enc.sv | 23 ++
 rtl/lcd_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the MCU-LCD 8080-style bus arbiter.
// Holds the requester indices, RS encodings and FSM state encoding.
package lcd_bus_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_INIT = 0;
  localparam int REQ_CPU  = 1;
  localparam int REQ_PIX  = 2;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/lcd_bus_prio_enc.sv
// Fixed-priority encoder for the three bus requesters (init > cpu > pixel).
// Ports:
//   req_i   - request vector, bit index = requester index
//   gnt_o   - one-hot grant for the highest-priority active request
//   valid_o - at least one request is active
module lcd_bus_prio_enc
  import lcd_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[REQ_INIT])     gnt_o[REQ_INIT] = 1'b1;
    else if (req_i[REQ_CPU]) gnt_o[REQ_CPU]  = 1'b1;
    else if (req_i[REQ_PIX]) gnt_o[REQ_PIX]  = 1'b1;
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates the 8080-style LCD bus between the init sequencer, CPU register
// access and the pixel streamer, and sequences CS/RS/WR/RD for each cycle.
// Build option: LCD_BUS_READ_EN enables real read cycles (rd_n strobe and
// lcd_din capture). Without it, reads run as strobe-less dummy cycles with
// read timing and return rdata = 0.
// Ports:
//   clk, rst                  - LCD-domain clock, synchronous active-high reset
//   req/req_rs/req_we         - per-requester request, RS and direction
//   req_wdata                 - per-requester write data, 16 bits each
//   ack, rdata                - completion pulse to grantee, read data
//   busy                      - FSM not idle
//   lcd_cs_n/rs/wr_n/rd_n     - bus control
//   lcd_dout/lcd_oe/lcd_din   - bus data out, drive enable, data in
//
// state  | meaning
// IDLE   | bus released, arbitrating
// SETUP  | cs_n low, rs/dout set up, one cycle
// STROBE | wr_n or rd_n low for *_LOW cycles
// HOLD   | strobe high for *_HIGH cycles, ack on last cycle
module lcd_bus_arbiter
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW    = 1,
  parameter int WR_HIGH   = 1,
  parameter int RD_LOW    = 4,
  parameter int RD_HIGH   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  req_rs,
  input  logic [2:0]  req_we,
  input  logic [47:0] req_wdata,
  output logic [2:0]  ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_dout,
  output logic        lcd_oe,
  input  logic [15:0] lcd_din
);

  localparam int WR_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int RD_MAX = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
  localparam int PH_MAX = (WR_MAX > RD_MAX) ? WR_MAX : RD_MAX;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = $clog2(MAX_BURST) + 1;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                rs_q, rs_d;
  logic                we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;

  logic [NUM_REQ-1:0]  enc_gnt;
  logic                enc_valid;
  logic                sel_rs, sel_we;
  logic [15:0]         sel_wdata;
  logic [PH_W-1:0]     strobe_last, hold_last;
  logic                burst_cont;
  logic                active;

  lcd_bus_prio_enc u_prio_enc (
    .req_i   (req),
    .gnt_o   (enc_gnt),
    .valid_o (enc_valid)
  );

  always_comb begin
    sel_rs    = 1'b0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (enc_gnt[n]) begin
        sel_rs    = req_rs[n];
        sel_we    = req_we[n];
        sel_wdata = req_wdata[16*n +: 16];
      end
    end
  end

  // Phase counter counts down to zero; the load value is length-1.
  // Dummy reads (no LCD_BUS_READ_EN) still use read timing.
  assign strobe_last = we_q ? PH_W'(WR_LOW - 1)  : PH_W'(RD_LOW - 1);
  assign hold_last   = we_q ? PH_W'(WR_HIGH - 1) : PH_W'(RD_HIGH - 1);

  // Pixel keeps the bus only while nobody with higher priority is waiting.
  assign burst_cont = gnt_q[REQ_PIX] & req[REQ_PIX] & ~req[REQ_CPU] &
                      ~req[REQ_INIT] & (cnt_q < CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rs_d    = rs_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          gnt_d   = enc_gnt;
          rs_d    = sel_rs;
          we_d    = sel_we;
          wdata_d = sel_wdata;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        phase_d = strobe_last;
        state_d = STROBE;
      end
      STROBE: begin
        if (phase_q == '0) begin
          phase_d = hold_last;
          state_d = HOLD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      HOLD: begin
        if (phase_q == '0) begin
          if (burst_cont) begin
            rs_d    = req_rs[REQ_PIX];
            we_d    = req_we[REQ_PIX];
            wdata_d = req_wdata[16*REQ_PIX +: 16];
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SETUP;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rs_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rs_q    <= rs_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign active   = (state_q != IDLE);
  assign busy     = active;
  assign lcd_cs_n = ~active;
  assign lcd_rs   = active & rs_q;
  assign lcd_dout = active ? wdata_q : 16'h0000;
  assign lcd_oe   = active & we_q;
  assign lcd_wr_n = ~((state_q == STROBE) & we_q);
  // Gated by rst so an aborted transfer never reports completion.
  assign ack      = (!rst && state_q == HOLD && phase_q == '0) ? gnt_q : '0;

`ifdef LCD_BUS_READ_EN
  logic [15:0] rdata_q;

  assign lcd_rd_n = ~((state_q == STROBE) & ~we_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == STROBE && !we_q && phase_q == '0) begin
      rdata_q <= lcd_din;
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_din;

  assign unused_din = ^lcd_din;
  assign lcd_rd_n   = 1'b1;
  assign rdata      = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
module tb_lcd_bus_arbiter;

`ifdef LCD_BUS_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  localparam int RL = 4;
  localparam int RH = 2;
  localparam int MB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_rs, req_we;
  logic [47:0] req_wdata;
  logic [15:0] lcd_din;

  logic [2:0]  ack0, ack1;
  logic [15:0] rdata0, rdata1, dout0, dout1;
  logic        busy0, cs0, rs0, wr0, rd0, oe0;
  logic        busy1, cs1, rs1, wr1, rd1, oe1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lcd_bus_arbiter dut0 (
    .clk(clk), .rst(rst), .req(req), .req_rs(req_rs), .req_we(req_we),
    .req_wdata(req_wdata), .ack(ack0), .rdata(rdata0), .busy(busy0),
    .lcd_cs_n(cs0), .lcd_rs(rs0), .lcd_wr_n(wr0), .lcd_rd_n(rd0),
    .lcd_dout(dout0), .lcd_oe(oe0), .lcd_din(lcd_din)
  );

  lcd_bus_arbiter #(.WR_LOW(3), .WR_HIGH(2)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_rs(req_rs), .req_we(req_we),
    .req_wdata(req_wdata), .ack(ack1), .rdata(rdata1), .busy(busy1),
    .lcd_cs_n(cs1), .lcd_rs(rs1), .lcd_wr_n(wr1), .lcd_rd_n(rd1),
    .lcd_dout(dout1), .lcd_oe(oe1), .lcd_din(lcd_din)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each transfer is a cycle index 0..len-1 from its start;
  // index 0 is setup, 1..slow is the strobe, the rest is the high phase.
  int          WL[2] = '{1, 3};
  int          WH[2] = '{1, 2};
  bit          m_act[2];
  bit          m_we[2], m_rs[2];
  int          m_pos[2], m_len[2], m_slow[2], m_g[2], m_words[2];
  logic [15:0] m_dat[2], m_rdat[2];

  task automatic m_start(input int k, input int g);
    m_act[k]  = 1'b1;
    m_pos[k]  = 0;
    m_g[k]    = g;
    m_we[k]   = req_we[g];
    m_rs[k]   = req_rs[g];
    m_dat[k]  = req_wdata[16*g +: 16];
    m_slow[k] = m_we[k] ? WL[k] : RL;
    m_len[k]  = 1 + m_slow[k] + (m_we[k] ? WH[k] : RH);
  endtask

  task automatic m_step(input int k);
    if (rst) begin
      m_act[k]   = 1'b0;
      m_words[k] = 0;
      m_rdat[k]  = 16'h0;
    end else if (m_act[k]) begin
      if (READ_EN && !m_we[k] && m_pos[k] == m_slow[k]) m_rdat[k] = lcd_din;
      if (m_pos[k] == m_len[k] - 1) begin
        if (m_g[k] == 2 && req == 3'b100 && m_words[k] < MB) begin
          m_start(k, 2);
          m_words[k]++;
        end else begin
          m_act[k]   = 1'b0;
          m_words[k] = 0;
        end
      end else begin
        m_pos[k]++;
      end
    end else if (req != 3'b000) begin
      m_start(k, req[0] ? 0 : (req[1] ? 1 : 2));
      m_words[k] = 1;
    end
  endtask

  function automatic logic [31:0] pack(input logic b, cs, rs, wr, rd, oe,
                                       input logic [2:0] a, input logic [15:0] d);
    return {7'b0, b, cs, rs, wr, rd, oe, a, d};
  endfunction

  task automatic cmp(input int k);
    bit          st;
    logic [2:0]  ack_e;
    logic [31:0] e;
    st    = m_act[k] && m_pos[k] >= 1 && m_pos[k] <= m_slow[k];
    ack_e = (m_act[k] && m_pos[k] == m_len[k] - 1 && !rst) ? 3'(1 << m_g[k]) : 3'b000;
    e = pack(m_act[k], !m_act[k], m_act[k] && m_rs[k], !(st && m_we[k]),
             READ_EN ? !(st && !m_we[k]) : 1'b1, m_act[k] && m_we[k], ack_e,
             m_act[k] ? m_dat[k] : 16'h0);
    if (k == 0) begin
      check("bus0", pack(busy0, cs0, rs0, wr0, rd0, oe0, ack0, dout0), e);
      if ((ack_e != 0 && !m_we[k]) || rst) check("rdata0", {16'h0, rdata0}, {16'h0, m_rdat[k]});
    end else begin
      check("bus1", pack(busy1, cs1, rs1, wr1, rd1, oe1, ack1, dout1), e);
      if ((ack_e != 0 && !m_we[k]) || rst) check("rdata1", {16'h0, rdata1}, {16'h0, m_rdat[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
    cmp(0);
    cmp(1);
  endtask

  task automatic idle(input int n);
    req = 3'b000;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int ack_c0, ack_c1, low_cnt, oe_seen, pulses, order, pix, init_after, nack;
    logic [15:0] rd_val;
    bit raised;

    rst = 1'b1; req = 3'b000; req_rs = 3'b000; req_we = 3'b000;
    req_wdata = '0; lcd_din = 16'h0;
    tick(); tick();
    check("rst_out", {busy0, cs0, wr0, rd0, oe0, ack0}, {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000});
    check("rst_rdata", rdata0, 16'h0);
    rst = 1'b0;
    tick();

    // single write
    req = 3'b010; req_we = 3'b010; req_rs = 3'b000; req_wdata = 48'h0000_0036_0000;
    tick();
    req = 3'b000;
    ack_c0 = -1; ack_c1 = -1; low_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      if (ack0 != 0 && ack_c0 < 0) ack_c0 = c;
      if (ack1 != 0 && ack_c1 < 0) ack_c1 = c;
      if (!wr1) low_cnt++;
      if (c == 2) check("wr_dout", dout0, 16'h0036);
      if (c == 3) check("wr_ack", ack0, 3'b010);
      if (c == 4) check("wr_cs_high", cs0, 1'b1);
    end
    check("wr_ack_cyc", ack_c0, 3);
    check("wr_ack_cyc_slow", ack_c1, 6);
    check("wr_low_slow", low_cnt, 3);

    // single read
    req = 3'b010; req_we = 3'b000; lcd_din = 16'h9341;
    tick();
    req = 3'b000;
    ack_c0 = -1; low_cnt = 0; oe_seen = 0; rd_val = 16'hffff;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      if (ack0 != 0 && ack_c0 < 0) begin ack_c0 = c; rd_val = rdata0; end
      if (!rd0) low_cnt++;
      if (oe0) oe_seen++;
    end
    check("rd_ack_cyc", ack_c0, 7);
    check("rd_low", low_cnt, READ_EN ? 4 : 0);
    check("rd_rdata", rd_val, READ_EN ? 16'h9341 : 16'h0000);
    check("rd_oe", oe_seen, 0);

    // pixel burst
    req = 3'b100; req_we = 3'b100;
    req_wdata[47:32] = 16'(($urandom()));
    tick();
    pulses = 0;
    for (int c = 0; c < 200 && !cs0; c++) begin
      if (!wr0) pulses++;
      req_wdata[47:32] = 16'($urandom());
      tick();
    end
    check("burst_words", pulses, MB);
    check("burst_gap_busy", busy0, 1'b0);
    idle(120);

    // priority order
    req = 3'b111; req_we = 3'b111; order = 0;
    for (int c = 0; c < 60 && req != 0; c++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (ack0[i]) begin
          order = order * 4 + i + 1;
          req[i] = 1'b0;
        end
    end
    check("prio_order", order, 27);
    idle(40);

    // init request raised during pixel word 5
    req = 3'b100; req_we = 3'b101; pix = 0; raised = 0; init_after = -1;
    for (int c = 0; c < 200 && init_after < 0; c++) begin
      tick();
      if (ack0 == 3'b100) pix++;
      if (ack0 == 3'b001) begin init_after = pix; req[0] = 1'b0; end
      if (pix == 4 && !raised && ack0 == 3'b000 && !cs0) begin req[0] = 1'b1; raised = 1; end
    end
    check("init_preempt", init_after, 5);
    idle(120);

    // reset mid-strobe
    req = 3'b010; req_we = 3'b010;
    tick();
    req = 3'b000;
    tick();
    check("strobe_wr", wr0, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid", {cs0, wr0, rd0, oe0, busy0}, 5'b11100);
    rst = 1'b0;
    nack = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack0 != 0 || ack1 != 0) nack++;
    end
    check("rst_no_ack", nack, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 399) == 0);
      req[0]    = ($urandom_range(0, 19) == 0);
      req[1]    = ($urandom_range(0, 9) == 0);
      req[2]    = req[2] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      req_rs    = 3'($urandom());
      req_we    = 3'($urandom_range(0, 7)) | 3'b100;
      if ($urandom_range(0, 3) == 0) req_we = 3'($urandom());
      req_wdata = {16'($urandom()), 32'($urandom())};
      lcd_din   = 16'($urandom());
      tick();
    end
    rst = 1'b0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
